// File: rtl/operand_regfile.sv
// MIPS GPR file plus HI/LO pair feeding registered operands to execute.
// A writeback in the same cycle as a read is forwarded into the captured operands.
module operand_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [$clog2(NUM_REGS)-1:0]   rs_addr,
  input  logic [$clog2(NUM_REGS)-1:0]   rt_addr,
  input  logic [1:0]                    op1_sel,
  input  logic                          wb_valid,
  input  logic [1:0]                    wb_mode,
  input  logic [$clog2(NUM_REGS)-1:0]   wb_rd,
  input  logic [2*DATA_W-1:0]           wb_result,
  output logic [DATA_W-1:0]             op1,
  output logic [DATA_W-1:0]             op2,
  output logic [DATA_W-1:0]             hi_out,
  output logic [DATA_W-1:0]             lo_out,
  output logic [15:0]                   wb_count
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [1:0] WB_GPR  = 2'd0;
  localparam logic [1:0] WB_HILO = 2'd1;
  localparam logic [1:0] WB_HI   = 2'd2;
  localparam logic [1:0] WB_LO   = 2'd3;

  localparam logic [1:0] SEL_GPR  = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_LO   = 2'd2;

  logic [NUM_REGS-1:0][DATA_W-1:0] gpr_q;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              gpr_we;
  logic [DATA_W-1:0] wb_lo_w, wb_hi_w, rs_val, rt_val;

  assign wb_lo_w = wb_result[DATA_W-1:0];
  assign wb_hi_w = wb_result[2*DATA_W-1:DATA_W];
  assign gpr_we  = wb_valid && (wb_mode == WB_GPR) && (wb_rd != '0);

  // Post-write views of the source registers; r0 stays zero even if targeted.
  always_comb begin
    rs_val = gpr_q[rs_addr];
    rt_val = gpr_q[rt_addr];
    if (gpr_we && (wb_rd == rs_addr)) rs_val = wb_lo_w;
    if (gpr_we && (wb_rd == rt_addr)) rt_val = wb_lo_w;
    if (rs_addr == '0) rs_val = '0;
    if (rt_addr == '0) rt_val = '0;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_valid) begin
      case (wb_mode)
        WB_HILO: begin hi_d = wb_hi_w; lo_d = wb_lo_w; end
        WB_HI:   hi_d = wb_lo_w;
        WB_LO:   lo_d = wb_lo_w;
        default: ;
      endcase
    end
  end

  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    if (rd_en) begin
      case (op1_sel)
        SEL_GPR: op1_d = rs_val;
        SEL_HI:  op1_d = hi_d;
        SEL_LO:  op1_d = lo_d;
        default: op1_d = '0;
      endcase
      op2_d = rt_val;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
      cnt_q <= '0;
    end else begin
      if (gpr_we) gpr_q[wb_rd] <= wb_lo_w;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      cnt_q <= cnt_d;
    end
  end

  // Unused upper address bits when NUM_REGS is not a power of two are harmless.
  logic unused_ok;
  assign unused_ok = &{1'b0, AW[0]};

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign wb_count = cnt_q;
endmodule

// File: tb/tb_operand_regfile.sv
// Directed table-driven bench for operand_regfile plus hand sequences for
// stall hold, reset during writeback and counter saturation.
module tb_operand_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [4:0]  rs_addr, rt_addr, wb_rd;
  logic [1:0]  op1_sel, wb_mode;
  logic        wb_valid;
  logic [63:0] wb_result;
  logic [31:0] op1, op2, hi_out, lo_out;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;

  operand_regfile dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .op1_sel(op1_sel), .wb_valid(wb_valid), .wb_mode(wb_mode), .wb_rd(wb_rd),
    .wb_result(wb_result), .op1(op1), .op2(op2), .hi_out(hi_out), .lo_out(lo_out),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd_en;
    logic [4:0]  rs, rt;
    logic [1:0]  sel;
    logic        wbv;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [31:0] e_op1, e_op2, e_hi, e_lo;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] sel, input logic wbv, input logic [1:0] mode,
                       input logic [4:0] rd, input logic [63:0] res);
    rd_en = r; rs_addr = rs; rt_addr = rt; op1_sel = sel;
    wb_valid = wbv; wb_mode = mode; wb_rd = rd; wb_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] sel, input logic wbv, input logic [1:0] mode,
                     input logic [4:0] rd, input logic [63:0] res,
                     input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] h,
                     input logic [31:0] l, input logic [15:0] c);
    vec_t v;
    v.name = n; v.rd_en = r; v.rs = rs; v.rt = rt; v.sel = sel; v.wbv = wbv;
    v.mode = mode; v.rd = rd; v.res = res;
    v.e_op1 = o1; v.e_op2 = o2; v.e_hi = h; v.e_lo = l; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    //   name         rd rs  rt  sel wbv md rd  result                  op1           op2           hi            lo            cnt
    add("rst_read",   1, 5,  6,  0,  0,  0, 0,  64'h0,                  32'h0,        32'h0,        32'h0,        32'h0,        16'd0);
    add("wr_r5",      0, 5,  6,  0,  1,  0, 5,  64'hDEAD_0000_1234_5678, 32'h0,       32'h0,        32'h0,        32'h0,        16'd1);
    add("rd_r5",      1, 5,  6,  0,  0,  0, 0,  64'h0,                  32'h1234_5678, 32'h0,       32'h0,        32'h0,        16'd1);
    add("byp_r7",     1, 7,  7,  0,  1,  0, 7,  64'h0000_0000_A5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,     32'h0,        16'd2);
    add("byp_r0",     1, 0,  0,  0,  1,  0, 0,  64'h0000_0000_FFFF_FFFF, 32'h0,       32'h0,        32'h0,        32'h0,        16'd3);
    add("wr_hilo",    0, 0,  0,  0,  1,  1, 0,  64'h0000_0001_FFFF_FFFE, 32'h0,       32'h0,        32'h1,        32'hFFFF_FFFE, 16'd4);
    add("rd_hi",      1, 0,  7,  1,  0,  0, 0,  64'h0,                  32'h1,        32'hA5A5_A5A5, 32'h1,       32'hFFFF_FFFE, 16'd4);
    add("rd_lo",      1, 0,  7,  2,  0,  0, 0,  64'h0,                  32'hFFFF_FFFE, 32'hA5A5_A5A5, 32'h1,      32'hFFFF_FFFE, 16'd4);
    add("byp_hi",     1, 0,  5,  1,  1,  2, 0,  64'h0000_0099_0000_0042, 32'h42,      32'h1234_5678, 32'h42,      32'hFFFF_FFFE, 16'd5);
    add("byp_lo",     1, 0,  5,  2,  1,  3, 0,  64'h0000_0055_0000_0077, 32'h77,      32'h1234_5678, 32'h42,      32'h77,       16'd6);
    add("sel_zero",   1, 5,  5,  3,  1,  0, 5,  64'hFFFF_0000_0000_CAFE, 32'h0,       32'hCAFE,     32'h42,       32'h77,       16'd7);
    add("rd_r7",      1, 7,  0,  0,  0,  0, 0,  64'h0,                  32'hA5A5_A5A5, 32'h0,       32'h42,       32'h77,       16'd7);

    drive(0, 0, 0, 0, 0, 0, 0, 64'h0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_op1", op1, 32'h0);
    chk("reset_cnt", {16'h0, wb_count}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd_en, vecs[i].rs, vecs[i].rt, vecs[i].sel, vecs[i].wbv,
            vecs[i].mode, vecs[i].rd, vecs[i].res);
      tick();
      chk({vecs[i].name, ".op1"}, op1, vecs[i].e_op1);
      chk({vecs[i].name, ".op2"}, op2, vecs[i].e_op2);
      chk({vecs[i].name, ".hi"},  hi_out, vecs[i].e_hi);
      chk({vecs[i].name, ".lo"},  lo_out, vecs[i].e_lo);
      chk({vecs[i].name, ".cnt"}, {16'h0, wb_count}, {16'h0, vecs[i].e_cnt});
    end

    // Stall: op1 must hold while r3 is rewritten underneath it.
    drive(0, 0, 0, 0, 1, 0, 3, 64'h11);  tick();
    drive(1, 3, 0, 0, 0, 0, 0, 64'h0);   tick();
    chk("stall_load", op1, 32'h11);
    drive(0, 3, 0, 0, 1, 0, 3, 64'h22);  tick();
    chk("stall_hold", op1, 32'h11);
    drive(0, 3, 0, 0, 0, 0, 0, 64'h0);   tick();
    chk("stall_hold2", op1, 32'h11);
    drive(1, 3, 0, 0, 0, 0, 0, 64'h0);   tick();
    chk("stall_release", op1, 32'h22);
    chk("stall_cnt", {16'h0, wb_count}, 32'd9);

    // Reset together with a writeback and a read: both are discarded.
    reset = 1'b1;
    drive(1, 3, 3, 1, 1, 1, 0, 64'h1234_5678_9ABC_DEF0);
    tick();
    reset = 1'b0;
    chk("rst_wb_op1", op1, 32'h0);
    chk("rst_wb_op2", op2, 32'h0);
    chk("rst_wb_hi", hi_out, 32'h0);
    chk("rst_wb_lo", lo_out, 32'h0);
    chk("rst_wb_cnt", {16'h0, wb_count}, 32'h0);
    drive(1, 3, 7, 0, 0, 0, 0, 64'h0);   tick();
    chk("rst_r3", op1, 32'h0);
    chk("rst_r7", op2, 32'h0);

    // Counter saturation.
    drive(0, 0, 0, 0, 1, 0, 0, 64'h0);
    for (int i = 0; i < 65534; i++) tick();
    chk("cnt_pre_sat", {16'h0, wb_count}, 32'h0000_FFFE);
    tick();
    chk("cnt_sat", {16'h0, wb_count}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("cnt_hold", {16'h0, wb_count}, 32'h0000_FFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
